// File: rtl/pf_sched_pkg.sv
// Shared types and defaults for the playfield port-A scheduler.
package pf_sched_pkg;

    localparam int PF_WORDS_DEFAULT       = 960;
    localparam int PF_ADDR_W              = 10;
    localparam int MAX_CPU_STREAK_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CPU_WR      = 3'd1,
        CPU_RD      = 3'd2,
        CPU_RD_DATA = 3'd3,
        FILL_WR     = 3'd4
    } sched_state_t;

endpackage

// File: rtl/pf_fill_counter.sv
// Fill engine bookkeeping: latched fill byte, word counter, last-word detect, busy/done.
module pf_fill_counter
    import pf_sched_pkg::*;
#(
    parameter int PF_WORDS = PF_WORDS_DEFAULT,
    parameter int ADDR_W   = PF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        start_value,
    input  logic              advance,
    output logic              busy,
    output logic              done,
    output logic              pending,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        value
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PF_WORDS - 1);

    // Set once the last word is granted; busy stays up through that write cycle.
    logic last_sent;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            value     <= '0;
            last_sent <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy      <= 1'b1;
                    addr      <= '0;
                    value     <= start_value;
                    last_sent <= 1'b0;
                end
            end else if (last_sent) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                last_sent <= 1'b0;
            end else if (advance) begin
                if (addr == LAST_ADDR) begin
                    last_sent <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

    assign pending = busy && !last_sent;

endmodule

// File: rtl/pf_port_scheduler.sv
// Playfield RAM port-A scheduler: CPU-priority arbitration with a bounded CPU streak
// against the fill engine. Optional macro PF_VBLANK_GATE_EN restricts fill slots to vblank.
module pf_port_scheduler
    import pf_sched_pkg::*;
#(
    parameter int PF_WORDS       = PF_WORDS_DEFAULT,
    parameter int ADDR_W         = PF_ADDR_W,
    parameter int MAX_CPU_STREAK = MAX_CPU_STREAK_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PF_VBLANK_GATE_EN
    input  logic              vblank,
`endif
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              fill_start,
    input  logic [7:0]        fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_we_l,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    localparam int                STREAK_W   = $clog2(MAX_CPU_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

    sched_state_t        state;
    logic [STREAK_W-1:0] streak;
    logic                fill_pending_raw;
    logic                fill_pending;
    logic [ADDR_W-1:0]   fill_addr;
    logic [7:0]          fill_val;
    logic                arb_slot;
    logic                cpu_new;
    logic                grant_cpu;
    logic                grant_fill;

    pf_fill_counter #(
        .PF_WORDS (PF_WORDS),
        .ADDR_W   (ADDR_W)
    ) u_fill (
        .clk         (clk),
        .rst         (rst),
        .start       (fill_start),
        .start_value (fill_value),
        .advance     (grant_fill),
        .busy        (fill_busy),
        .done        (fill_done),
        .pending     (fill_pending_raw),
        .addr        (fill_addr),
        .value       (fill_val)
    );

`ifdef PF_VBLANK_GATE_EN
    assign fill_pending = fill_pending_raw && vblank;
`else
    assign fill_pending = fill_pending_raw;
`endif

    // Ack cycles are dead slots, so a held cpu_req is never re-accepted on its ack edge.
    always_comb begin
        arb_slot   = (state == IDLE) || (state == FILL_WR);
        cpu_new    = cpu_req && !cpu_ack;
        grant_fill = arb_slot && fill_pending && (!cpu_new || (streak >= STREAK_MAX));
        grant_cpu  = arb_slot && cpu_new && !grant_fill;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (!fill_pending_raw || grant_fill) begin
            streak <= '0;
        end else if (grant_cpu && fill_pending) begin
            streak <= streak + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            ram_we_l  <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            cpu_ack  <= 1'b0;
            ram_we_l <= 1'b1;
            case (state)
                IDLE, FILL_WR: begin
                    if (grant_cpu) begin
                        ram_addr <= cpu_addr;
                        if (cpu_we) begin
                            state     <= CPU_WR;
                            ram_we_l  <= 1'b0;
                            ram_wdata <= cpu_wdata;
                            cpu_ack   <= 1'b1;
                        end else begin
                            state <= CPU_RD;
                        end
                    end else if (grant_fill) begin
                        state     <= FILL_WR;
                        ram_we_l  <= 1'b0;
                        ram_addr  <= fill_addr;
                        ram_wdata <= fill_val;
                    end else begin
                        state <= IDLE;
                    end
                end
                CPU_RD: begin
                    cpu_rdata <= ram_rdata;
                    cpu_ack   <= 1'b1;
                    state     <= CPU_RD_DATA;
                end
                CPU_WR, CPU_RD_DATA: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pf_port_scheduler.sv
// Self-checking bench for pf_port_scheduler; also exercises PF_VBLANK_GATE_EN when defined.
module tb_pf_port_scheduler;
    import pf_sched_pkg::*;

    localparam int PFW = 960;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [9:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       fill_start = 1'b0;
    logic [7:0] fill_value = '0;
    logic       fill_busy;
    logic       fill_done;
    logic       ram_we_l;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
`ifdef PF_VBLANK_GATE_EN
    logic       vblank = 1'b1;
`endif

    always #5 clk = ~clk;

    pf_port_scheduler #(
        .PF_WORDS       (PFW),
        .ADDR_W         (10),
        .MAX_CPU_STREAK (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PF_VBLANK_GATE_EN
        .vblank     (vblank),
`endif
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .ram_we_l   (ram_we_l),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Port-A RAM: read data follows the scheduler's registered address.
    logic [7:0] mem [0:1023] = '{default: 8'h00};
    always @(posedge clk) if (!ram_we_l) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    // Reference contents: what the bench itself has written.
    logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

    typedef struct packed {
        logic       is_fill;
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t wlog[$];
    int  ack_cnt = 0;
    int  done_cnt = 0;
    int  fill_cnt = 0;

    always @(negedge clk) begin
        if (!ram_we_l) wlog.push_back({!cpu_ack, ram_addr, ram_wdata});
        if (!ram_we_l && !cpu_ack) fill_cnt++;
        if (cpu_ack) ack_cnt++;
        if (fill_done) done_cnt++;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpu_op(input logic we, input logic [9:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output logic wr_ok);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!cpu_ack && lat < 20);
        rd    = cpu_rdata;
        wr_ok = !ram_we_l && (ram_addr == a) && (ram_wdata == d);
        // Hold the request through the ack edge before dropping it.
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic pulse_fill(input logic [7:0] v);
        @(negedge clk);
        fill_value = v; fill_start = 1'b1;
        @(posedge clk); #1;
        fill_start = 1'b0;
    endtask

    task automatic wait_fill(input int f0, input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(posedge clk); #1;
            if (fill_cnt - f0 >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int d0, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(posedge clk); #1;
            if (done_cnt > d0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic check_fill(input int base, input logic [7:0] v, input string tag);
        int n = 0;
        int bad = 0;
        for (int i = base; i < wlog.size(); i++) begin
            if (wlog[i].is_fill) begin
                if (wlog[i].addr != 10'(n) || wlog[i].data != v) bad++;
                n++;
            end
        end
        chk({tag, " fill write count"}, n, PFW);
        chk({tag, " fill order/value errors"}, bad, 0);
        for (int i = 0; i < PFW; i++) ref_mem[i] = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cpu_ack"},   cpu_ack,   0);
        chk({tag, " cpu_rdata"}, cpu_rdata, 0);
        chk({tag, " fill_busy"}, fill_busy, 0);
        chk({tag, " fill_done"}, fill_done, 0);
        chk({tag, " ram_we_l"},  ram_we_l,  1);
        chk({tag, " ram_addr"},  ram_addr,  0);
        chk({tag, " ram_wdata"}, ram_wdata, 0);
    endtask

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    vec_t vt [9];

    logic [7:0] rd;
    int         lat;
    logic       wr_ok;
    bit         ok;
    int         base, d0, f0, nwr;
    bit         stop;

    initial begin
        vt[0] = '{1'b1, 10'h123, 8'hA5, 8'h00, 1};
        vt[1] = '{1'b0, 10'h123, 8'h00, 8'hA5, 2};
        vt[2] = '{1'b1, 10'h000, 8'h11, 8'h00, 1};
        vt[3] = '{1'b1, 10'h3BF, 8'h22, 8'h00, 1};
        vt[4] = '{1'b0, 10'h000, 8'h00, 8'h11, 2};
        vt[5] = '{1'b0, 10'h3BF, 8'h00, 8'h22, 2};
        vt[6] = '{1'b1, 10'h3FF, 8'hFF, 8'h00, 1};
        vt[7] = '{1'b0, 10'h3FF, 8'h00, 8'hFF, 2};
        vt[8] = '{1'b0, 10'h124, 8'h00, 8'h00, 2};

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            cpu_op(vt[i].we, vt[i].addr, vt[i].wdata, rd, lat, wr_ok);
            chk($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
            if (vt[i].we) begin
                chk($sformatf("vec%0d write cmd", i), wr_ok, 1);
                ref_mem[vt[i].addr] = vt[i].wdata;
            end else begin
                chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
            end
        end

        for (int i = 0; i < 40; i++) begin
            logic       we;
            logic [9:0] a;
            logic [7:0] d;
            we = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 1023));
            d  = 8'($urandom);
            cpu_op(we, a, d, rd, lat, wr_ok);
            chk($sformatf("rand%0d latency", i), lat, we ? 1 : 2);
            if (we) ref_mem[a] = d;
            else    chk($sformatf("rand%0d rdata @%0h", i, a), rd, ref_mem[a]);
        end

        // Full fill with an idle CPU: back-to-back writes 0..959.
        base = wlog.size(); d0 = done_cnt;
        pulse_fill(8'h00);
        chk("fill0 busy after start", fill_busy, 1);
        wait_done(d0, 3000, ok);
        chk("fill0 done seen", ok, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("fill0 done pulses", done_cnt - d0, 1);
        chk("fill0 busy fell", fill_busy, 0);
        chk("fill0 total writes", wlog.size() - base, PFW);
        check_fill(base, 8'h00, "fill0");
        cpu_op(1'b0, 10'd959, 8'h00, rd, lat, wr_ok);
        chk("fill0 read 959", rd, 8'h00);

        // Starvation bound: CPU writes continuously while a fill runs.
        base = wlog.size(); d0 = done_cnt; nwr = 0; stop = 1'b0;
        fork
            begin
                int k = 0;
                int guard = 0;
                @(negedge clk);
                cpu_req = 1'b1; cpu_we = 1'b1;
                cpu_addr = 10'(960 + k % 64); cpu_wdata = 8'($urandom);
                while (guard < 20000) begin
                    @(posedge clk); #1; guard++;
                    if (cpu_ack) begin
                        ref_mem[cpu_addr] = cpu_wdata;
                        nwr++;
                        if (stop) begin
                            @(posedge clk); #1;
                            break;
                        end
                        k++;
                        cpu_addr = 10'(960 + k % 64); cpu_wdata = 8'($urandom);
                    end
                end
                cpu_req = 1'b0;
            end
            begin
                repeat (7) @(negedge clk);
                pulse_fill(8'h3F);
                wait_done(d0, 12000, ok);
                chk("starve done seen", ok, 1);
                stop = 1'b1;
            end
        join
        begin
            int run = 0;
            int nf = 0;
            int bad = 0;
            int ncpu = 0;
            for (int i = base; i < wlog.size(); i++) begin
                if (wlog[i].is_fill) begin
                    if (nf > 0 && run != 4) bad++;
                    nf++;
                    run = 0;
                end else begin
                    run++;
                    ncpu++;
                end
            end
            chk("starve cpu runs between fills != 4", bad, 0);
            chk("starve cpu writes on bus", ncpu, nwr);
        end
        check_fill(base, 8'h3F, "starve");
        for (int i = 0; i < 4; i++) begin
            cpu_op(1'b0, 10'(960 + i), 8'h00, rd, lat, wr_ok);
            chk($sformatf("starve readback %0d", 960 + i), rd, ref_mem[960 + i]);
        end

        // Simultaneous CPU request and fill start in IDLE.
        repeat (2) @(posedge clk);
        base = wlog.size(); d0 = done_cnt; f0 = fill_cnt;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd970; cpu_wdata = 8'h5A;
        fill_value = 8'h77; fill_start = 1'b1;
        @(posedge clk); #1;
        fill_start = 1'b0;
        chk("simul cpu ack first", cpu_ack, 1);
        chk("simul cpu write addr", ram_addr, 10'd970);
        chk("simul busy", fill_busy, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        ref_mem[970] = 8'h5A;
        wait_fill(f0, 100, 2000, ok);
        chk("simul fill progress", ok, 1);
        pulse_fill(8'h99);
        wait_done(d0, 3000, ok);
        chk("simul done seen", ok, 1);
        chk("simul write log size", wlog.size() - base, PFW + 1);
        chk("simul first write", wlog[base], {1'b0, 10'd970, 8'h5A});
        chk("simul second write", wlog[base + 1], {1'b1, 10'd0, 8'h77});
        check_fill(base, 8'h77, "simul");

        // Reset in the middle of a fill.
        repeat (3) @(posedge clk);
        base = wlog.size(); f0 = fill_cnt;
        pulse_fill(8'hC3);
        wait_fill(f0, 501, 2000, ok);
        chk("rst-mid fill progress", ok, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst-mid");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= 500; i++) ref_mem[i] = 8'hC3;
        repeat (2) @(posedge clk);
        base = wlog.size(); d0 = done_cnt;
        pulse_fill(8'h11);
        wait_done(d0, 3000, ok);
        chk("refill done seen", ok, 1);
        check_fill(base, 8'h11, "refill");

`ifdef PF_VBLANK_GATE_EN
        begin
            int f1;
            vblank = 1'b0;
            base = wlog.size(); d0 = done_cnt; f0 = fill_cnt;
            pulse_fill(8'h5C);
            repeat (20) @(posedge clk);
            #1;
            chk("vblank-low no writes", fill_cnt - f0, 0);
            chk("vblank-low busy", fill_busy, 1);
            vblank = 1'b1;
            wait_fill(f0, 100, 500, ok);
            chk("vblank resume", ok, 1);
            vblank = 1'b0;
            @(posedge clk); #1;
            f1 = fill_cnt;
            repeat (20) @(posedge clk);
            #1;
            chk("vblank stall frozen", fill_cnt - f1, 0);
            chk("vblank stall busy", fill_busy, 1);
            vblank = 1'b1;
            wait_done(d0, 3000, ok);
            chk("vblank done seen", ok, 1);
            check_fill(base, 8'h5C, "vblank");
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final fill_busy", fill_busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pf_port_scheduler.md
Name: pf_port_scheduler

Overview:
- Sequences the single bus-side port of the playfield RAM, which holds 960 tile-ID bytes.
- Two requesters share the port: the CPU bus (reads and writes) and an internal hardware fill engine that clears or fills the whole playfield with one byte value.
- Sits between the CPU address decode and the playfield RAM port A. The video-side port B is untouched.
- CPU has priority. A bounded-streak rule prevents the fill from starving.

Parameters:
- PF_WORDS, 960, number of playfield bytes written by a fill (addresses 0..PF_WORDS-1).
- ADDR_W, 10, playfield address width.
- MAX_CPU_STREAK, 4, consecutive CPU grants allowed while a fill is pending before the fill is forced one slot.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle pulse: access complete
- cpu_rdata  out  8  read data, valid in the cpu_ack cycle of a read
- fill_start  in  1  one-cycle pulse: begin fill
- fill_value  in  8  byte to fill; sampled on an accepted fill_start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse after the last fill write
- ram_we_l  out  1  RAM write enable, active-low
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, valid one cycle after the address is presented

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: cpu_ack=0, cpu_rdata=0, fill_busy=0, fill_done=0, ram_we_l=1, ram_addr=0, ram_wdata=0. Internal: fill counter=0, streak=0, state=IDLE.
- All outputs are registered. A grant decided at edge k drives the RAM command during cycle k+1.
- States:
  - IDLE: no command in flight.
  - CPU_WR: write command issued.
  - CPU_RD: read address issued.
  - CPU_RD_DATA: capture ram_rdata.
  - FILL_WR: fill write issued.
- Slot arbitration, evaluated each edge in IDLE or a completing state, for a new, un-acked request:
  - cpu_req and fill pending and streak==MAX_CPU_STREAK -> fill slot, streak cleared.
  - Otherwise cpu_req -> CPU slot, streak+1 if a fill is pending.
  - Otherwise fill pending -> fill slot.
- CPU write:
  - Command cycle has ram_we_l=0, ram_addr=cpu_addr, ram_wdata=cpu_wdata.
  - cpu_ack pulses in that same cycle.
  - Latency is 1 cycle from acceptance.
- CPU read:
  - Address cycle has ram_we_l=1; the next cycle registers ram_rdata into cpu_rdata.
  - cpu_ack pulses with the valid data, 2 cycles after acceptance.
  - ram_addr holds until then.
- CPU hold rule: the CPU drops cpu_req in the cycle after cpu_ack. A request still high in the ack cycle is not re-accepted that edge; at most one access per req/ack pair.
- Fill:
  - fill_start in IDLE or during CPU traffic with no fill active latches fill_value, sets fill_busy the next cycle, and clears the counter.
  - Each fill slot writes fill_value to the counter address, then increments the counter.
  - After the write to PF_WORDS-1: fill_busy falls and fill_done pulses in the following cycle.
  - fill_start while fill_busy is ignored; the value and counter are unchanged.
- Non-command cycles: ram_we_l=1 and ram_addr holds its last value.
- Counter width: ADDR_W; no wrap past PF_WORDS-1.
- Mid-operation reset: rst mid-fill or mid-read aborts immediately, applies the reset values, and no ack is produced.
- Simultaneous cpu_req and fill_start in IDLE: the CPU is served first; the fill becomes pending the next cycle.

Optional Feature:
- Macro: PF_VBLANK_GATE_EN.
- Defined:
  - Adds input port vblank (1 bit).
  - Fill slots are granted only while vblank=1; the streak rule applies only within vblank.
  - Outside vblank the fill stalls with fill_busy held high and the counter frozen.
- Undefined: no vblank port; fill slots are granted regardless of video timing.

Decomposition:
- Shared package pf_sched_pkg:
  - state enum (IDLE, CPU_WR, CPU_RD, CPU_RD_DATA, FILL_WR);
  - PF_WORDS_DEFAULT and PF_ADDR_W constants.
- Natural sub-module pf_fill_counter: latched value, address counter, last-word detect, busy/done generation.
- The scheduler FSM and arbitration stay in the top module.

Test Plan:
- CPU write then read: write addr 0x123 data 0xA5.
  - ram_we_l=0 with addr 0x123 in cycle k+1 and cpu_ack pulses there.
  - A read of 0x123 returns cpu_rdata=0xA5 with cpu_ack 2 cycles after acceptance.
- Full fill with no CPU traffic: fill_start with value 0x00.
  - Exactly 960 write cycles to addresses 0..959 in order.
  - fill_done pulses once and fill_busy falls.
  - A read of 959 returns 0x00.
- Fill starvation bound: fill 0x3F with cpu_req held continuously (back-to-back writes).
  - After every 4 CPU grants exactly one fill write occurs.
  - The fill completes; no CPU ack is lost.
- Simultaneous start: cpu_req and fill_start in the same IDLE cycle.
  - CPU write issued first; the fill write to address 0 follows next.
  - fill_start repeated mid-fill does not change the value or counter.
- Reset mid-fill: rst asserted at counter=500.
  - All outputs return to reset values asynchronously and fill_busy=0.
  - A new fill after release starts at address 0.
- With PF_VBLANK_GATE_EN: start a fill with vblank=0.
  - No fill writes occur and fill_busy=1.
  - Raising vblank resumes writes from the frozen counter.
